// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_buffered
// Purpose  : Buffered UART transmitter. A producer pushes words into an
//            internal FIFO. A bit-timing FSM drains the FIFO and serialises
//            each word as a frame made of one start bit (low), PAYLOAD_BITS
//            data bits sent LSB first, and one stop bit (high).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   1             system clock, rising edge
//   reset      in   1             asynchronous reset, active low
//   write_en   in   1             push request
//   write_data in   PAYLOAD_BITS  word to push (sampled on an accepted push)
//   full       out  1             FIFO holds BUFFER_SIZE entries (registered)
//   empty      out  1             FIFO holds no entries (registered)
//   overflow   out  1             one-cycle pulse after a push into a full FIFO
//   busy       out  1             a frame is in progress
//   tx         out  1             serial line, idle high (registered)
// ============================================================================
module uart_tx_buffered #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BIT_RATE     = 115200,
  parameter int PAYLOAD_BITS = 8,
  parameter int BUFFER_SIZE  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    write_en,
  input  logic [PAYLOAD_BITS-1:0] write_data,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow,
  output logic                    busy,
  output logic                    tx
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int CYCLES_PER_BIT = CLK_FREQ / BIT_RATE;
  localparam int CYC_W          = $clog2(CYCLES_PER_BIT);
  localparam int PTR_W          = $clog2(BUFFER_SIZE);
  localparam int CNT_W          = PTR_W + 1;
  localparam int BIT_W          = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CYCLES_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAYLOAD_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUFFER_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // --------------------------------------------------------------------------
  logic [PAYLOAD_BITS-1:0] mem_q [BUFFER_SIZE];
  logic [PAYLOAD_BITS-1:0] mem_d [BUFFER_SIZE];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q,  count_d;
  logic                    full_q,   full_d;
  logic                    empty_q,  empty_d;
  logic                    overflow_q, overflow_d;

  logic                    push;
  logic                    pop;
  logic [PAYLOAD_BITS-1:0] head_word;

  // --------------------------------------------------------------------------
  // Transmit FSM state
  // --------------------------------------------------------------------------
  state_t                  state_q, state_d;
  logic [CYC_W-1:0]        cyc_q,   cyc_d;
  logic [BIT_W-1:0]        bit_q,   bit_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic                    tx_q,    tx_d;

  // A push is only accepted while the registered full flag is low. The pop
  // side never looks at the incoming word, so a word always spends at least
  // one cycle in storage before it can be transmitted.
  assign push      = write_en & ~full_q;
  assign head_word = mem_q[rd_ptr_q];

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (push) begin
      mem_d[wr_ptr_q] = write_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Flags are registered copies of the next occupancy so they line up
    // with the count they describe.
    full_d     = (count_d == CNT_FULL);
    empty_d    = (count_d == '0);
    overflow_d = write_en & full_q;
  end

  // --------------------------------------------------------------------------
  // FSM next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!empty_q) begin
          pop     = 1'b1;
          shift_d = head_word;
          cyc_d   = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = ST_DATA;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end

      ST_DATA: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if (bit_q == BIT_LAST) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + BIT_W'(1);
            tx_d    = shift_d[0];
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end

      ST_STOP: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          bit_d = '0;
          // Chain straight into the next start bit when more data is
          // waiting, so back-to-back frames carry no idle gap.
          if (!empty_q) begin
            pop     = 1'b1;
            shift_d = head_word;
            tx_d    = 1'b0;
            state_d = ST_START;
          end else begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end

      default: begin
        tx_d    = 1'b1;
        cyc_d   = '0;
        bit_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  // Storage is not reset: clearing the pointers and count is enough to make
  // any stale contents unreachable.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
      cyc_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign tx       = tx_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
`default_nettype wire
